pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//   Generic elastic pipeline stage register that replaces hand-written per-stage latches (IF/ID, ID/IX, IX/IM, IM/IW).
//   Sits between two pipeline stages and carries a packed control/data bus of DATA_W bits.
//   Uses valid/ready handshake, an optional 2-entry skid buffer, flush (bubble insertion) and saturating stall/bubble counters.
// PARAMETERS
//   DATA_W           32  width of packed stage payload (pc, operands, control bits)
//   SKID             1   1: two-entry skid buffer, in_ready registered; 0: single entry, in_ready = !m_valid | out_ready
//   CLEAR_ON_BUBBLE  1   1: out_data forced to 0 whenever out_valid=0; 0: out_data holds last value
//   CNT_W            16  width of performance counters
// PORTS
//   clk         in   1       clock; all state updates on negedge clk, same as every pipeline register in the design
//   rst         in   1       synchronous reset, active-high, sampled on negedge clk
//   in_valid    in   1       upstream stage has a payload
//   in_ready    out  1       stage can accept a payload this cycle
//   in_data     in   DATA_W  upstream payload
//   flush       in   1       kill all held payloads (branch/jump redirect)
//   out_valid   out  1       payload available to downstream stage
//   out_ready   in   1       downstream accepts (=!stall of downstream)
//   out_data    out  DATA_W  payload to downstream
//   stall_cnt   out  CNT_W   cycles with out_valid=1 & out_ready=0, saturating
//   bubble_cnt  out  CNT_W   cycles with out_valid=0, saturating
// BEHAVIOUR
//   - Reset: m_valid=s_valid=0, m_data=s_data=0, out_valid=0, out_data=0, in_ready=1, stall_cnt=bubble_cnt=0.
//   - acc = in_valid & in_ready; drn = out_valid & out_ready; both evaluated before the edge.
//   - Latency: 1 cycle; payload accepted at edge N is on out_data after edge N. FIFO order is always kept.
//   - States (SKID=1): EMPTY (m=0,s=0), ONE (m=1,s=0), FULL (m=1,s=1). in_ready = !s_valid (registered).
//       EMPTY: acc -> ONE (m<=in).
//       ONE: acc&drn -> ONE (m<=in); acc&!drn -> FULL (s<=in); !acc&drn -> EMPTY; else hold.
//       FULL: drn -> ONE (m<=s); no accept possible; else hold.
//   - SKID=0: states EMPTY/ONE only; in_ready combinational = !m_valid | out_ready; m<=in on acc.
//   - flush: highest priority after rst; next state EMPTY; payload accepted same cycle is discarded.
//     drn that cycle still counts as a completed transfer for downstream. Counters are unaffected.
//   - rst and flush together: rst wins; the result is identical to reset.
//   - out_valid=m_valid; out_data=m_data, or 0 if CLEAR_ON_BUBBLE & !m_valid.
//   - Payload bits are never modified; width is exactly DATA_W, with no sign or zero extension.
//   - Counters: +1 per edge when their condition holds and rst=0; hold at 2^CNT_W-1; flush does not clear them.
//   - in_valid may drop without acceptance (upstream may retract); the block must not latch unaccepted data.
//   - Held payloads stay stable while out_valid & !out_ready.
// TESTING
//   1. rst=1 for 2 edges -> out_valid=0, out_data=0, in_ready=1, counters=0.
//   2. Streaming: out_ready=1, in_data=1,2,3,4 on consecutive edges -> out_data 1,2,3,4 one cycle later, stall_cnt=0.
//   3. Skid (SKID=1): out_ready=0 after accepting 0xA, 0xB -> state FULL and in_ready=0, 0xC held off; out_data stays 0xA.
//      Releasing out_ready then yields 0xA, 0xB, 0xC in order, with stall_cnt equal to the number of stalled cycles.
//   4. Flush in FULL with in_valid=1 (0xD) -> next cycle out_valid=0, out_data=0, in_ready=1; 0xD never appears.
//   5. Saturation: CNT_W=4, idle 20 cycles -> bubble_cnt=15 and holds; rst mid-stream with FULL -> EMPTY, counters 0.
//   6. SKID=0: out_valid=1, out_ready=1, in_valid=1 -> in_ready=1 same cycle, back-to-back transfer without a bubble.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic valid/ready pipeline stage register with optional skid entry and perf counters
//
// Generic stage register placed between two pipeline stages. It carries a packed
// DATA_W-bit payload under a valid/ready handshake. It can optionally hold a second
// (skid) entry so that in_ready comes straight from a flop. It also supports flush
// (bubble insertion) and keeps saturating stall/bubble counters.
// All state updates on the falling edge of clk, like every other stage register.
//
// Ports:
//   clk         clock (state updates on negedge)
//   rst         synchronous active-high reset, sampled on negedge
//   in_valid    upstream has a payload
//   in_ready    stage can accept a payload this cycle
//   in_data     upstream payload, DATA_W bits
//   flush       kill all held payloads (redirect)
//   out_valid   payload available to downstream
//   out_ready   downstream accepts
//   out_data    payload to downstream, DATA_W bits
//   stall_cnt   cycles with out_valid & !out_ready, saturating
//   bubble_cnt  cycles with !out_valid, saturating

module pipe_stage_reg #(
    parameter int DATA_W          = 32,
    parameter bit SKID            = 1'b1,
    parameter bit CLEAR_ON_BUBBLE = 1'b1,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // State is encoded directly as {s_valid, m_valid}; 2'b10 is unreachable.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              m_valid;
    logic              s_valid;
    logic [DATA_W-1:0] m_data;
    logic [DATA_W-1:0] s_data;
    logic [1:0]        state;
    logic              acc;
    logic              drn;

    assign state = {s_valid, m_valid};

    // With a skid entry, in_ready depends only on a flop, which breaks the
    // combinational ready path back to the upstream stage. Without one, the
    // stage can refill in the same cycle that it drains.
    assign in_ready  = SKID ? !s_valid : (!m_valid | out_ready);
    assign acc       = in_valid & in_ready;
    assign drn       = m_valid & out_ready;

    assign out_valid = m_valid;
    assign out_data  = (CLEAR_ON_BUBBLE && !m_valid) ? '0 : m_data;

    always_ff @(negedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_data  <= '0;
            s_data  <= '0;
        end else if (flush) begin
            // Anything accepted this cycle is dropped as well. The data regs
            // keep their contents so that CLEAR_ON_BUBBLE=0 still holds the last value.
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (SKID) begin
            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        m_valid <= 1'b1;
                        m_data  <= in_data;
                    end
                end
                ST_ONE: begin
                    if (acc && drn) begin
                        m_data <= in_data;
                    end else if (acc) begin
                        s_valid <= 1'b1;
                        s_data  <= in_data;
                    end else if (drn) begin
                        m_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so the only move is to promote the skid entry.
                    if (drn) begin
                        s_valid <= 1'b0;
                        m_data  <= s_data;
                    end
                end
                default: begin
                    m_valid <= 1'b0;
                    s_valid <= 1'b0;
                end
            endcase
        end else begin
            if (acc) begin
                m_valid <= 1'b1;
                m_data  <= in_data;
            end else if (drn) begin
                m_valid <= 1'b0;
            end
        end
    end

    // The counters sample the handshake as seen before the edge. Flush leaves them alone.
    always_ff @(negedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (m_valid && !out_ready && stall_cnt != CNT_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (!m_valid && bubble_cnt != CNT_MAX) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end

endmodule
